// File: rtl/serial_paralelo_align_pkg.sv
// Shared definitions for the serial lane, used by both the transmit-side
// serializer and the receive-side aligner/deserializer.
//
// Contents:
//    COM_CHAR          - comma character used to find byte alignment
//    IDLE_CHAR         - idle fill character sent between data bytes
//    BC_THRESH_DEFAULT - consecutive aligned COMs needed before lock
//    alignState_t      - receiver alignment state encoding
package serial_paralelo_align_pkg;

   localparam logic [7:0] COM_CHAR          = 8'hBC;
   localparam logic [7:0] IDLE_CHAR         = 8'h7C;
   localparam int         BC_THRESH_DEFAULT = 4;

   // Encoding 2'd3 is unused; the receiver treats it as a reason to re-hunt.
   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      SYNC   = 2'd1,
      ACTIVE = 2'd2
   } alignState_t;

endpackage

// File: rtl/serial_paralelo_align.sv
// Receive-side deserializer for the PHY serial lane.
//
// The lane carries bytes MSB-first, one bit per clk_32f. The block hunts
// for COM_CHAR at any bit offset, then confirms alignment by seeing
// BC_THRESH consecutive COMs on 8-bit boundaries. Once locked it emits one
// byte every 8 clocks, flagging whether that byte is real data or fill.
//
// Ports:
//    clk_32f     - bit clock, the only clock in the block
//    rst_L       - asynchronous active-low reset
//    data_in     - serial bit, sampled on posedge clk_32f
//    data_out    - last complete byte received while locked (held 8 clocks)
//    valid_out   - data_out is neither COM_CHAR nor IDLE_CHAR
//    byte_strobe - one-cycle pulse on the edge data_out updates
//    active      - alignment locked
module serial_paralelo_align #(
   parameter int         BC_THRESH = serial_paralelo_align_pkg::BC_THRESH_DEFAULT,
   parameter logic [7:0] COM_CHAR  = serial_paralelo_align_pkg::COM_CHAR,
   parameter logic [7:0] IDLE_CHAR = serial_paralelo_align_pkg::IDLE_CHAR
) (
   input  logic       clk_32f,
   input  logic       rst_L,
   input  logic       data_in,
   output logic [7:0] data_out,
   output logic       valid_out,
   output logic       byte_strobe,
   output logic       active
);

   import serial_paralelo_align_pkg::*;

   logic [7:0]  shiftReg_q;
   logic [7:0]  shiftReg_d;
   logic [2:0]  bitCnt_q;
   logic [3:0]  comCnt_q;
   alignState_t state_q;
   logic [7:0]  dataOut_q;
   logic        validOut_q;
   logic        byteStrobe_q;
   logic        active_q;

   logic        boundary;
   logic        isCom;
   logic        lastCom;

   // The byte including the bit being sampled on this edge. Every decision
   // looks at this value so a byte is recognised on the edge of its last bit.
   assign shiftReg_d = {shiftReg_q[6:0], data_in};
   assign boundary   = (bitCnt_q == 3'd7);
   assign isCom      = (shiftReg_d == COM_CHAR);
   assign lastCom    = ((comCnt_q + 4'd1) == 4'(BC_THRESH));

   assign data_out    = dataOut_q;
   assign valid_out   = validOut_q;
   assign byte_strobe = byteStrobe_q;
   assign active      = active_q;

   // Serial shift register, always running regardless of alignment state.
   always_ff @(posedge clk_32f or negedge rst_L) begin
      if (!rst_L) begin
         shiftReg_q <= 8'h00;
      end else begin
         shiftReg_q <= shiftReg_d;
      end
   end

   // Bit position within the aligned byte. Held at zero while hunting so
   // the first hunt match starts a fresh byte; in SYNC a mismatch at the
   // boundary wraps 7->0, which agrees with the zero HUNT expects.
   always_ff @(posedge clk_32f or negedge rst_L) begin
      if (!rst_L) begin
         bitCnt_q <= 3'd0;
      end else if ((state_q == SYNC) || (state_q == ACTIVE)) begin
         bitCnt_q <= bitCnt_q + 3'd1;
      end else begin
         bitCnt_q <= 3'd0;
      end
   end

   // Count of consecutive aligned COMs; the hunt match itself counts as one.
   // Frozen once locked since alignment is never re-checked.
   always_ff @(posedge clk_32f or negedge rst_L) begin
      if (!rst_L) begin
         comCnt_q <= 4'd0;
      end else begin
         case (state_q)
            HUNT: begin
               comCnt_q <= isCom ? 4'd1 : 4'd0;
            end
            SYNC: begin
               if (boundary) begin
                  comCnt_q <= isCom ? (comCnt_q + 4'd1) : 4'd0;
               end
            end
            ACTIVE: begin
               comCnt_q <= comCnt_q;
            end
            default: begin
               comCnt_q <= 4'd0;
            end
         endcase
      end
   end

   // Alignment FSM with registered outputs. Outputs only move in ACTIVE
   // (plus active itself on the locking edge), and data_out/valid_out are
   // held between boundaries so a 4f-rate sampler sees stable values.
   always_ff @(posedge clk_32f or negedge rst_L) begin
      if (!rst_L) begin
         state_q      <= HUNT;
         dataOut_q    <= 8'h00;
         validOut_q   <= 1'b0;
         byteStrobe_q <= 1'b0;
         active_q     <= 1'b0;
      end else begin
         byteStrobe_q <= 1'b0;
         case (state_q)
            HUNT: begin
               if (isCom) begin
                  state_q <= SYNC;
               end
            end
            SYNC: begin
               if (boundary) begin
                  if (isCom && lastCom) begin
                     state_q  <= ACTIVE;
                     active_q <= 1'b1;
                  end else if (!isCom) begin
                     state_q <= HUNT;
                  end
               end
            end
            ACTIVE: begin
               if (boundary) begin
                  dataOut_q    <= shiftReg_d;
                  validOut_q   <= (shiftReg_d != COM_CHAR) && (shiftReg_d != IDLE_CHAR);
                  byteStrobe_q <= 1'b1;
               end
            end
            default: begin
               state_q  <= HUNT;
               active_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_paralelo_align.sv
// Directed testbench for serial_paralelo_align.
//
// Bits are driven on the falling edge and outputs are observed 1ns after
// the rising edge that sampled each bit. The bench tracks whether the
// receiver should be locked and which byte it should be holding, and
// checks strobe/data/valid/active after every bit.
module tb_serial_paralelo_align;

   logic       clk_32f;
   logic       rst_L;
   logic       data_in;
   logic [7:0] data_out;
   logic       valid_out;
   logic       byte_strobe;
   logic       active;

   int         assertCount;
   int         failCount;
   bit         locked;
   logic [7:0] lastData;

   serial_paralelo_align #(
      .BC_THRESH (4)
   ) dut (
      .clk_32f     (clk_32f),
      .rst_L       (rst_L),
      .data_in     (data_in),
      .data_out    (data_out),
      .valid_out   (valid_out),
      .byte_strobe (byte_strobe),
      .active      (active)
   );

   // Free-running bit clock, 10ns period.
   initial begin
      clk_32f = 1'b0;
      forever #5 clk_32f = ~clk_32f;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Drive one serial bit and wait until just after it has been sampled.
   task automatic applyStimulus(input logic b);
      @(negedge clk_32f);
      data_in = b;
      @(posedge clk_32f);
      #1;
   endtask

   // Send one byte MSB-first, checking outputs after each bit. lockHere
   // marks the byte whose last bit should raise active.
   task automatic sendByte(input logic [7:0] b, input bit lockHere, input string tag);
      for (int i = 7; i >= 0; i--) begin
         applyStimulus(b[i]);
         if (locked) begin
            checkOutput({tag, "_active"}, active, 1);
            if (i != 0) begin
               checkOutput({tag, "_strobe"}, byte_strobe, 0);
               checkOutput({tag, "_hold"}, data_out, lastData);
            end else begin
               checkOutput({tag, "_strobe"}, byte_strobe, 1);
               checkOutput({tag, "_data"}, data_out, b);
               checkOutput({tag, "_valid"}, valid_out, (b != 8'hBC) && (b != 8'h7C));
               lastData = b;
            end
         end else begin
            checkOutput({tag, "_strobe"}, byte_strobe, 0);
            checkOutput({tag, "_data"}, data_out, 8'h00);
            checkOutput({tag, "_valid"}, valid_out, 0);
            checkOutput({tag, "_active"}, active, (lockHere && (i == 0)) ? 1 : 0);
         end
      end
      if (lockHere) begin
         locked = 1'b1;
      end
   endtask

   // Pulse reset between clock edges and confirm outputs clear at once.
   task automatic applyReset(input string tag);
      @(posedge clk_32f);
      #3;
      rst_L   = 1'b0;
      data_in = 1'b0;
      #1;
      checkOutput({tag, "_data"}, data_out, 8'h00);
      checkOutput({tag, "_valid"}, valid_out, 0);
      checkOutput({tag, "_strobe"}, byte_strobe, 0);
      checkOutput({tag, "_active"}, active, 0);
      @(posedge clk_32f);
      #3;
      rst_L    = 1'b1;
      locked   = 1'b0;
      lastData = 8'h00;
   endtask

   initial begin
      logic [7:0] b;
      assertCount = 0;
      failCount   = 0;
      locked      = 1'b0;
      lastData    = 8'h00;
      rst_L       = 1'b0;
      data_in     = 1'b0;

      // Reset state at power-up.
      #1;
      checkOutput("por_data", data_out, 8'h00);
      checkOutput("por_valid", valid_out, 0);
      checkOutput("por_strobe", byte_strobe, 0);
      checkOutput("por_active", active, 0);
      repeat (2) @(posedge clk_32f);
      #3;
      rst_L = 1'b1;

      // Lock on four COMs, then fill and data bytes.
      $display("[TB] lock sequence");
      for (int i = 0; i < 3; i++) sendByte(8'hBC, 1'b0, "lock_com");
      sendByte(8'hBC, 1'b1, "lock_com4");
      sendByte(8'h7C, 1'b0, "lock_idle");
      sendByte(8'h5A, 1'b0, "lock_5a");
      sendByte(8'hA5, 1'b0, "lock_a5");

      // Long locked stream mixing COM, IDLE and random data.
      $display("[TB] stability stream");
      for (int i = 0; i < 100; i++) begin
         case (i % 4)
            0:       b = 8'hBC;
            1:       b = 8'h7C;
            default: b = 8'($urandom_range(0, 255));
         endcase
         sendByte(b, 1'b0, "stable");
      end
      sendByte(8'h5A, 1'b0, "stable_last");

      // Asynchronous reset while locked with a valid byte held.
      applyReset("midrst1");

      // Random bit offset before the COMs; must align on the COM boundary.
      $display("[TB] misaligned start");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'($urandom_range(0, 1)));
         checkOutput("mis_pre_active", active, 0);
      end
      for (int i = 0; i < 3; i++) sendByte(8'hBC, 1'b0, "mis_com");
      sendByte(8'hBC, 1'b1, "mis_com4");
      sendByte(8'h3C, 1'b0, "mis_3c");

      applyReset("midrst2");

      // Broken sync: a non-COM in SYNC drops back to HUNT.
      $display("[TB] broken sync");
      sendByte(8'hBC, 1'b0, "brk_com");
      sendByte(8'hBC, 1'b0, "brk_com");
      sendByte(8'h11, 1'b0, "brk_11");
      for (int i = 0; i < 3; i++) sendByte(8'hBC, 1'b0, "brk_recom");
      sendByte(8'hBC, 1'b1, "brk_recom4");
      sendByte(8'h42, 1'b0, "brk_42");

      applyReset("midrst3");

      // One COM short of threshold followed by idle fill never locks.
      $display("[TB] threshold edge");
      for (int i = 0; i < 3; i++) sendByte(8'hBC, 1'b0, "thr_com");
      for (int i = 0; i < 6; i++) sendByte(8'h7C, 1'b0, "thr_idle");

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
